dmem_sized: RTL and testbench
=============================

// Module: dmem_sized
// PURPOSE
//  Parametrised data memory for the RV32I datapath with byte/half/word access, sign or
//  zero extension, misalignment and range fault reporting, and a valid/ready request
//  port with configurable wait states.
//  Sits between the load/store stage and the memory array.
//  Lets the core model slow memory and implement LB/LH/LW/LBU/LHU/SB/SH/SW in one place.
// PARAMETERS
//  ADDR_W       8   word-address width; array depth = 2**ADDR_W 32-bit words
//  WAIT_CYCLES  0   extra wait cycles before the access commits (0..15)
//  CNT_W        4   width of the wait counter; must hold WAIT_CYCLES
// PORTS
//  clk           in   1   single clock, all state updates on posedge
//  rst           in   1   synchronous, active-high reset
//  req_valid     in   1   request present
//  req_ready     out  1   block can accept a request (high only in IDLE)
//  req_we        in   1   1 = store, 0 = load
//  req_size      in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned  in   1   load zero-extends when 1 (LBU/LHU); ignored for word and stores
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  rsp_valid     out  1   one-cycle pulse: access complete
//  rsp_rdata     out  32  extended load data; 0 for stores and faults
//  rsp_fault     out  1   valid with rsp_valid: misaligned, out-of-range or illegal size
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, req_ready=1 after reset, rsp_valid=0, rsp_rdata=0,
//   rsp_fault=0. Array contents are not reset.
//  FSM IDLE -> BUSY on req_valid&&req_ready; latch we/size/unsigned/addr/wdata;
//   cnt <= WAIT_CYCLES.
//  FSM BUSY: if cnt!=0, cnt<=cnt-1; if cnt==0, perform access and go to RESP.
//  FSM RESP: rsp_valid=1 for exactly this cycle; then IDLE.
//  Latency: acceptance edge to rsp_valid high = WAIT_CYCLES+1 edges.
//   Throughput: one request per WAIT_CYCLES+3 cycles.
//  req_ready=0 in BUSY and RESP; requests held there are ignored until IDLE. No rsp backpressure.
//  Word index = addr[ADDR_W+1:2]; lane = addr[1:0].
//  Fault if any of:
//   - size==11
//   - half with addr[0]=1
//   - word with addr[1:0]!=0
//   - addr[31:ADDR_W+2]!=0 (out of range)
//   On fault: no array write; rsp_rdata=0; rsp_fault=1.
//  Store: write only enabled byte lanes of the target word (byte mask 0001<<lane,
//   0011<<lane, or 1111). Data is replicated across lanes; other bytes are unchanged.
//   Commit occurs on the BUSY(cnt==0) edge.
//  Load: read word at the same edge; shift right by 8*lane; sign- or zero-extend from
//   bit 7/15 per req_unsigned; register into rsp_rdata.
//  Store response: rsp_rdata=0, rsp_fault=0 unless faulted.
//  rsp_rdata/rsp_fault hold until the next RESP update; only rsp_valid qualifies them.
//  Reset mid-operation: reset wins over any state. A store still in BUSY with cnt!=0, or
//   at the commit edge, is dropped (reset has priority over the write). No response
//   is emitted.
//  Top address 4*(2**ADDR_W)-1 is legal for byte access; one past it faults.
// STRUCTURE
//  Shared package dmem_pkg:
//   - SIZE_B/SIZE_H/SIZE_W/SIZE_X size codes
//   - FSM state encoding IDLE/BUSY/RESP
//  Sub-module dmem_lane_align (combinational), which produces:
//   - fault
//   - 4-bit byte mask
//   - lane-replicated write data
//   - extended load data from (size, unsigned, lane, word)
//  The top level holds the FSM, counter, request latches and array.
// TESTING
//  1. WAIT_CYCLES=0: SW 0xDEADBEEF @0x10, then LW @0x10
//     -> rsp_rdata=0xDEADBEEF, fault=0; rsp_valid 1 edge after accept.
//  2. SB 0x80 @0x11, then:
//     - LW @0x10 -> 0xDEAD80EF
//     - LB @0x11 -> 0xFFFFFF80
//     - LBU @0x11 -> 0x00000080
//  3. SH 0x1234 @0x12, then:
//     - LH @0x12 -> 0x00001234
//     - LW @0x10 -> 0x123480EF
//  4. Misaligned and illegal requests:
//     - LH @0x13 -> fault=1, rdata=0
//     - SW @0x12 (wdata 0) -> fault=1; follow-up LW @0x10 -> 0x123480EF (unchanged)
//     - size=11 -> fault=1
//  5. ADDR_W=8: LB @0x3FF -> fault=0; LB @0x400 -> fault=1.
//  6. WAIT_CYCLES=3:
//     - rsp_valid exactly 4 edges after accept
//     - req_ready low for 5 cycles
//     - second req_valid held high is accepted only after return to IDLE
//     - rst pulsed in BUSY during SW -> no rsp, target word unchanged

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the sized data memory: access size codes, the
// controller state encoding and small lane helpers used by the aligner.
package dmem_pkg;

  // Access size codes as presented on req_size.
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  // Request controller states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

  // Byte-enable pattern for an access of the given size starting at lane.
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] mask;
    case (size)
      SIZE_B:  mask = 4'b0001 << lane;
      SIZE_H:  mask = 4'b0011 << lane;
      SIZE_W:  mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Copy the right-aligned store data into every lane it could land in,
  // so the byte mask alone selects what reaches the array.
  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] rep;
    case (size)
      SIZE_B:  rep = {4{data[7:0]}};
      SIZE_H:  rep = {2{data[15:0]}};
      SIZE_W:  rep = data;
      default: rep = 32'h0000_0000;
    endcase
    return rep;
  endfunction

  // True when the size code is illegal or the lane breaks natural alignment.
  function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = lane[0];
      SIZE_W:  bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_sized_if.sv
// Request/response bus between the load/store stage and the sized data memory.
// The master issues requests and consumes responses; the slave is the memory.
interface dmem_sized_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane logic for one latched access: fault detection, store
// byte mask and lane-replicated write data, and load shift/extension.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic        fault,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [1:0]  lane;
  logic        range_fault;
  logic [31:0] shifted;

  assign lane        = addr[1:0];
  // Any address bit above the array's byte range makes the access out of range.
  assign range_fault = ((addr >> (ADDR_W + 2)) != 32'h0000_0000);
  assign shifted     = rword >> {lane, 3'b000};

  // Fault and store-side lane selection.
  always_comb begin
    fault     = 1'b0;
    byte_en   = 4'b0000;
    wdata_rep = 32'h0000_0000;
    if (range_fault || size_misaligned(size, lane)) begin
      fault = 1'b1;
    end else begin
      byte_en   = byte_mask(size, lane);
      wdata_rep = lane_replicate(size, wdata);
    end
  end

  // Load-side extraction: the addressed bytes are already at bit 0 after the shift.
  always_comb begin
    rdata_ext = 32'h0000_0000;
    if (fault) begin
      rdata_ext = 32'h0000_0000;
    end else begin
      case (size)
        SIZE_B:  rdata_ext = is_unsigned ? {24'h00_0000, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
        SIZE_H:  rdata_ext = is_unsigned ? {16'h0000, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
        SIZE_W:  rdata_ext = shifted;
        default: rdata_ext = 32'h0000_0000;
      endcase
    end
  end

endmodule

// File: rtl/dmem_sized.sv
// Sized data memory for the RV32I load/store stage: accepts one request at a
// time, optionally stalls WAIT_CYCLES cycles, then commits the access and
// presents a single-cycle response.
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 0,
  parameter int CNT_W       = 4
) (
  input logic         clk,
  input logic         rst,
  dmem_sized_if.slave bus
);

  localparam int               DEPTH    = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              commit;

  // Request fields captured at acceptance; the bus may change afterwards.
  logic              lat_we;
  logic [1:0]        lat_size;
  logic              lat_unsigned;
  logic [31:0]       lat_addr;
  logic [31:0]       lat_wdata;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       rd_word;

  logic              fault;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_rep;
  logic [31:0]       rdata_ext;

  logic              ready_reg;
  logic              valid_reg;
  logic [31:0]       rdata_reg;
  logic              fault_reg;

  assign word_idx = lat_addr[ADDR_W+1:2];
  assign rd_word  = mem[word_idx];

  dmem_lane_align #(
    .ADDR_W      (ADDR_W)
  ) u_align (
    .size        (lat_size),
    .is_unsigned (lat_unsigned),
    .addr        (lat_addr),
    .wdata       (lat_wdata),
    .rword       (rd_word),
    .fault       (fault),
    .byte_en     (byte_en),
    .wdata_rep   (wdata_rep),
    .rdata_ext   (rdata_ext)
  );

  assign bus.req_ready = ready_reg;
  assign bus.rsp_valid = valid_reg;
  assign bus.rsp_rdata = rdata_reg;
  assign bus.rsp_fault = fault_reg;

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the accept and commit strobes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        // req_ready is high throughout IDLE, so valid alone completes the handshake.
        if (bus.req_valid) begin
          accept     = 1'b1;
          state_next = BUSY;
        end else begin
          state_next = IDLE;
        end
      end
      BUSY: begin
        if (cnt == CNT_ZERO) begin
          commit     = 1'b1;
          state_next = RESP;
        end else begin
          state_next = BUSY;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Wait-state counter: loaded on accept, counts down to zero while BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= CNT_ZERO;
    end else if (accept) begin
      cnt <= CNT_LOAD;
    end else if ((state == BUSY) && (cnt != CNT_ZERO)) begin
      cnt <= cnt - CNT_ONE;
    end else begin
      cnt <= cnt;
    end
  end

  // Capture the request on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we       <= 1'b0;
      lat_size     <= SIZE_B;
      lat_unsigned <= 1'b0;
      lat_addr     <= 32'h0000_0000;
      lat_wdata    <= 32'h0000_0000;
    end else if (accept) begin
      lat_we       <= bus.req_we;
      lat_size     <= bus.req_size;
      lat_unsigned <= bus.req_unsigned;
      lat_addr     <= bus.req_addr;
      lat_wdata    <= bus.req_wdata;
    end else begin
      lat_we       <= lat_we;
      lat_size     <= lat_size;
      lat_unsigned <= lat_unsigned;
      lat_addr     <= lat_addr;
      lat_wdata    <= lat_wdata;
    end
  end

  // Ready and response registers; rdata/fault hold until the next commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_reg <= 1'b1;
      valid_reg <= 1'b0;
      rdata_reg <= 32'h0000_0000;
      fault_reg <= 1'b0;
    end else begin
      ready_reg <= (state_next == IDLE);
      valid_reg <= commit;
      if (commit) begin
        rdata_reg <= (lat_we || fault) ? 32'h0000_0000 : rdata_ext;
        fault_reg <= fault;
      end else begin
        rdata_reg <= rdata_reg;
        fault_reg <= fault_reg;
      end
    end
  end

  // Array byte-lane write; contents are never reset, but reset blocks a pending commit.
  always_ff @(posedge clk) begin
    if (!rst && commit && lat_we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_sized.sv
// Self-checking bench for dmem_sized. Two instances (0 and 3 wait cycles)
// share the clock and reset. Stimulus pushes expected responses into a
// per-instance queue; a negedge monitor pops and compares on rsp_valid.
// The reference memory is a flat byte array indexed by byte address.
module tb_dmem_sized;
  import dmem_pkg::*;

  localparam int AW = 8;
  localparam int NB = 4 * (2 ** AW);

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          due;
  } rsp_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  rsp_exp_t q0[$];
  rsp_exp_t q1[$];
  logic [7:0] ref_mem [2][NB];
  int   low_run = 0;
  int   last_low_run = 0;

  dmem_sized_if if0 ();
  dmem_sized_if if1 ();

  dmem_sized #(.ADDR_W(AW), .WAIT_CYCLES(0), .CNT_W(4)) dut0 (
    .clk (clk), .rst (rst), .bus (if0.slave));
  dmem_sized #(.ADDR_W(AW), .WAIT_CYCLES(3), .CNT_W(4)) dut1 (
    .clk (clk), .rst (rst), .bus (if1.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
  endtask

  // Reference rules: illegal size, natural misalignment or beyond the array all fault.
  function automatic bit model_fault(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 1'b1;
    if (a >= 32'(NB)) return 1'b1;
    if ((a % (32'd1 << sz)) != 32'd0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_access(input int d, input bit we, input logic [1:0] sz, input bit uns,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] rd, output logic flt);
    int n;
    rd  = 32'd0;
    flt = model_fault(sz, a);
    if (!flt) begin
      n = 1 << sz;
      for (int i = 0; i < n; i++) begin
        if (we) ref_mem[d][int'(a) + i] = 8'(wd >> (8 * i));
        else    rd = rd | (32'(ref_mem[d][int'(a) + i]) << (8 * i));
      end
      if (!we && n < 4 && !uns && rd[8*n-1]) rd = rd | ~((32'd1 << (8 * n)) - 32'd1);
    end
  endtask

  task automatic drive(input int d, input bit v, input bit we, input logic [1:0] sz,
                       input bit uns, input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin
      if0.req_valid = v; if0.req_we = we; if0.req_size = sz;
      if0.req_unsigned = uns; if0.req_addr = a; if0.req_wdata = wd;
    end else begin
      if1.req_valid = v; if1.req_we = we; if1.req_size = sz;
      if1.req_unsigned = uns; if1.req_addr = a; if1.req_wdata = wd;
    end
  endtask

  // Issue one request (called at a negedge); returns the acceptance cycle or -1.
  task automatic issue(input int d, input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd, input bit keep,
                       input bit use_c, input logic [31:0] c_rd, input bit c_flt,
                       input bit push, output int acc);
    int n;
    logic rdy;
    logic [31:0] mrd;
    logic mflt;
    rsp_exp_t e;
    drive(d, 1'b1, we, sz, uns, a, wd);
    n = 0;
    rdy = (d == 0) ? if0.req_ready : if1.req_ready;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
      rdy = (d == 0) ? if0.req_ready : if1.req_ready;
    end
    if (!rdy) begin
      total++;
      $display("FAIL accept_timeout: dut%0d req_ready stayed %b, required 1", d, rdy);
      drive(d, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    if (push) begin
      model_access(d, we, sz, uns, a, wd, mrd, mflt);
      e.rdata = use_c ? c_rd : mrd;
      e.fault = use_c ? c_flt : mflt;
      e.due   = acc + wait_of(d) + 1;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(negedge clk);
    if (!keep) drive(d, 1'b0, we, sz, uns, a, wd);
  endtask

  task automatic check_rsp(input int d, input logic v, input logic [31:0] r, input logic f);
    rsp_exp_t e;
    int qn;
    if (v) begin
      qn = (d == 0) ? q0.size() : q1.size();
      if (qn == 0) begin
        total++;
        $display("FAIL unexpected_rsp: dut%0d rsp_valid=1 rdata=%h, required no response", d, r);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("rdata_dut%0d", d), r, e.rdata);
        chk($sformatf("fault_dut%0d", d), 32'(f), 32'(e.fault));
        chk($sformatf("latency_dut%0d", d), 32'(cyc), 32'(e.due));
      end
    end
  endtask

  // Response monitor for both instances.
  always @(negedge clk) begin
    check_rsp(0, if0.rsp_valid, if0.rsp_rdata, if0.rsp_fault);
    check_rsp(1, if1.rsp_valid, if1.rsp_rdata, if1.rsp_fault);
  end

  // Length of the most recent run of req_ready low on the wait-state instance.
  always @(negedge clk) begin
    if (rst) low_run = 0;
    else if (!if1.req_ready) low_run = low_run + 1;
    else if (low_run != 0) begin
      last_low_run = low_run;
      low_run = 0;
    end
  end

  task automatic rand_req(input int d);
    int r, acc;
    logic [31:0] a;
    logic [1:0] sz;
    r = $urandom_range(0, 9);
    if (r < 6)      a = 32'($urandom_range(0, 63));
    else if (r < 9) a = 32'($urandom_range(NB - 64, NB - 1));
    else if (r[0])  a = 32'(NB) + 32'($urandom_range(0, 4000));
    else            a = 32'h8000_0000 | ($urandom & 32'h0000_00ff);
    sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    issue(d, 1'($urandom), sz, 1'($urandom), a, $urandom, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, acc);
  endtask

  initial begin
    int acc, acc2, n;
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_ready0", 32'(if0.req_ready), 32'd1);
    chk("reset_valid0", 32'(if0.rsp_valid), 32'd0);
    chk("reset_rdata0", if0.rsp_rdata, 32'd0);
    chk("reset_fault0", 32'(if0.rsp_fault), 32'd0);
    chk("reset_ready1", 32'(if1.req_ready), 32'd1);
    chk("reset_valid1", 32'(if1.rsp_valid), 32'd0);

    // Give the exercised windows known contents.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) begin
        issue(d, 1'b1, SIZE_W, 1'b0, 32'(4 * w), $urandom, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, acc);
        issue(d, 1'b1, SIZE_W, 1'b0, 32'(NB - 64 + 4 * w), $urandom, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, acc);
      end
    end

    // Directed sequence on the zero-wait instance with fixed expected values.
    issue(0, 1'b1, SIZE_W, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, acc);
    issue(0, 1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, acc);
    issue(0, 1'b1, SIZE_B, 1'b0, 32'h11, 32'h80, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, acc);
    issue(0, 1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD80EF, 1'b0, 1'b1, acc);
    issue(0, 1'b0, SIZE_B, 1'b0, 32'h11, 32'h0, 1'b0, 1'b1, 32'hFFFFFF80, 1'b0, 1'b1, acc);
    issue(0, 1'b0, SIZE_B, 1'b1, 32'h11, 32'h0, 1'b0, 1'b1, 32'h00000080, 1'b0, 1'b1, acc);
    issue(0, 1'b1, SIZE_H, 1'b0, 32'h12, 32'h1234, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, acc);
    issue(0, 1'b0, SIZE_H, 1'b0, 32'h12, 32'h0, 1'b0, 1'b1, 32'h00001234, 1'b0, 1'b1, acc);
    issue(0, 1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'h123480EF, 1'b0, 1'b1, acc);
    issue(0, 1'b0, SIZE_H, 1'b0, 32'h13, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, acc);
    issue(0, 1'b1, SIZE_W, 1'b0, 32'h12, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, acc);
    issue(0, 1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'h123480EF, 1'b0, 1'b1, acc);
    issue(0, 1'b0, SIZE_X, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, acc);
    issue(0, 1'b0, SIZE_B, 1'b0, 32'h3FF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, acc);
    issue(0, 1'b0, SIZE_B, 1'b0, 32'h400, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, acc);

    // Wait-state instance: store then a load held valid through BUSY/RESP.
    issue(1, 1'b1, SIZE_W, 1'b0, 32'h24, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, acc);
    issue(1, 1'b0, SIZE_W, 1'b0, 32'h24, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1, acc2);
    chk("held_req_accept_cycle", 32'(acc2 - acc), 32'd6);
    repeat (8) @(negedge clk);
    chk("ready_low_cycles", 32'(last_low_run), 32'd5);

    // Reset during BUSY (cnt!=0) and on the commit edge drops the store.
    for (int k = 2; k <= 4; k += 2) begin
      issue(1, 1'b1, SIZE_W, 1'b0, 32'h20, 32'h5A5A5A5A ^ 32'(k), 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, acc);
      repeat (k - 1) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("midop_reset_ready", 32'(if1.req_ready), 32'd1);
      chk("midop_reset_valid", 32'(if1.rsp_valid), 32'd0);
      chk("midop_reset_rdata", if1.rsp_rdata, 32'd0);
      chk("midop_reset_fault", 32'(if1.rsp_fault), 32'd0);
      repeat (6) @(negedge clk);
      issue(1, 1'b0, SIZE_W, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, acc);
    end

    // Randomised traffic against the byte-array model.
    for (int i = 0; i < 120; i++) begin
      rand_req(0);
      rand_req(1);
    end

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: %0d/%0d responses outstanding, required 0", q0.size(), q1.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
